micro_sequencer: RTL and testbench



---
 rtl/micro_sequencer.sv | 176 +++++++++++++++++
 tb/tb_micro_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// micro_sequencer: next micro-address generator for the microprogrammed MIPS control unit.
// Latency: the next upc is registered and appears one cycle after seq_ctl/dispatch inputs are sampled.
// Backpressure: stall is raised combinationally while waiting on memory or a multicycle unit; HALTED ignores all inputs.
//
// Ports:
//   clk, rst_n             clock (rising edge) and synchronous active-low reset
//   seq_ctl                sequencing field of the current microinstruction
//   disp1_addr/disp2_addr  first/second-level dispatch table outputs
//   mem_ready, mc_done     memory access complete / multicycle result valid
//   upc                    current micro-address (control-store ROM address)
//   stall                  datapath hold (combinational)
//   illegal_op, timeout    sticky trap-cause flags, cleared by FETCH
//   halted                 sequencer halted, leaves only through reset
//   fetch_cnt              count of FETCH transitions taken (wraps)

module micro_sequencer #(
   parameter int                 UADDR_W      = 5,
   parameter logic [UADDR_W-1:0] FETCH_ADDR   = 5'd0,
   parameter logic [UADDR_W-1:0] TRAP_ADDR    = 5'd30,
   parameter logic [UADDR_W-1:0] ILLEGAL_CODE = 5'd31,
   parameter int                 MAX_WAIT     = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [2:0]         seq_ctl,
   input  logic [UADDR_W-1:0] disp1_addr,
   input  logic [UADDR_W-1:0] disp2_addr,
   input  logic               mem_ready,
   input  logic               mc_done,
   output logic [UADDR_W-1:0] upc,
   output logic               stall,
   output logic               illegal_op,
   output logic               timeout,
   output logic               halted,
   output logic [15:0]        fetch_cnt
);

   // sequencing field encoding
   localparam logic [2:0] SEQ_NEXT     = 3'b000;
   localparam logic [2:0] SEQ_FETCH    = 3'b001;
   localparam logic [2:0] SEQ_DISP1    = 3'b010;
   localparam logic [2:0] SEQ_DISP2    = 3'b011;
   localparam logic [2:0] SEQ_WAIT_MEM = 3'b100;
   localparam logic [2:0] SEQ_WAIT_MC  = 3'b101;
   localparam logic [2:0] SEQ_HALT     = 3'b110;
   localparam logic [2:0] SEQ_RSVD     = 3'b111;

   // wait counter must be able to hold MAX_WAIT-1
   localparam int WCNT_W = $clog2(MAX_WAIT) + 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAX_WAIT - 1);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_HOLD_MC = 2'd1,
      ST_HALTED  = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [UADDR_W-1:0]  upc_nxt;
   logic [UADDR_W-1:0]  upc_inc;
   logic [UADDR_W-1:0]  disp_sel;
   logic                illegal_nxt;
   logic                timeout_nxt;
   logic [15:0]         fetch_cnt_nxt;
   logic [WCNT_W-1:0]   wait_cnt, wait_cnt_nxt;

   assign upc_inc  = upc + UADDR_W'(1);
   // DISP1 and DISP2 share the load/trap path; only the source differs
   assign disp_sel = (seq_ctl == SEQ_DISP2) ? disp2_addr : disp1_addr;
   assign halted   = (state == ST_HALTED);

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_RUN;
         upc        <= FETCH_ADDR;
         illegal_op <= 1'b0;
         timeout    <= 1'b0;
         fetch_cnt  <= 16'd0;
         wait_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         upc        <= upc_nxt;
         illegal_op <= illegal_nxt;
         timeout    <= timeout_nxt;
         fetch_cnt  <= fetch_cnt_nxt;
         wait_cnt   <= wait_cnt_nxt;
      end
   end

   // next-state and datapath control
   always_comb begin
      state_nxt     = state;
      upc_nxt       = upc;
      illegal_nxt   = illegal_op;
      timeout_nxt   = timeout;
      fetch_cnt_nxt = fetch_cnt;
      wait_cnt_nxt  = wait_cnt;
      stall         = 1'b0;

      case (state)
         ST_RUN: begin
            case (seq_ctl)
               SEQ_NEXT: begin
                  upc_nxt = upc_inc;
               end
               SEQ_FETCH, SEQ_RSVD: begin
                  upc_nxt       = FETCH_ADDR;
                  fetch_cnt_nxt = fetch_cnt + 16'd1;
                  illegal_nxt   = 1'b0;
                  timeout_nxt   = 1'b0;
               end
               SEQ_DISP1, SEQ_DISP2: begin
                  // only the reserved code traps; every other value,
                  // TRAP_ADDR included, is loaded as-is
                  if (disp_sel == ILLEGAL_CODE) begin
                     upc_nxt     = TRAP_ADDR;
                     illegal_nxt = 1'b1;
                  end else begin
                     upc_nxt = disp_sel;
                  end
               end
               SEQ_WAIT_MEM: begin
                  if (mem_ready) begin
                     upc_nxt = upc_inc;
                  end else begin
                     stall = 1'b1;
                  end
               end
               SEQ_WAIT_MC: begin
                  if (mc_done) begin
                     upc_nxt = upc_inc;
                  end else begin
                     // this cycle already counts as the first hold cycle
                     stall        = 1'b1;
                     state_nxt    = ST_HOLD_MC;
                     wait_cnt_nxt = WCNT_W'(1);
                  end
               end
               SEQ_HALT: begin
                  state_nxt = ST_HALTED;
               end
               default: begin
                  upc_nxt = upc;
               end
            endcase
         end

         ST_HOLD_MC: begin
            stall = 1'b1;
            // a result arriving on the final hold cycle beats the timeout
            if (mc_done) begin
               upc_nxt      = upc_inc;
               state_nxt    = ST_RUN;
               wait_cnt_nxt = '0;
            end else if (wait_cnt == WCNT_LAST) begin
               upc_nxt      = TRAP_ADDR;
               timeout_nxt  = 1'b1;
               state_nxt    = ST_RUN;
               wait_cnt_nxt = '0;
            end else begin
               wait_cnt_nxt = wait_cnt + WCNT_W'(1);
            end
         end

         ST_HALTED: begin
            state_nxt = ST_HALTED;
         end

         default: begin
            state_nxt = ST_RUN;
         end
      endcase
   end

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed test-plan sequences followed by randomized traffic,
// all compared against a cycle-level behavioural model of the sequencer.
module tb_micro_sequencer;

   localparam int MAX_WAIT = 32;
   localparam int M_RUN  = 0;
   localparam int M_HOLD = 1;
   localparam int M_HALT = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  seq_ctl;
   logic [4:0]  disp1_addr, disp2_addr;
   logic        mem_ready, mc_done;
   logic [4:0]  upc;
   logic        stall, illegal_op, timeout, halted;
   logic [15:0] fetch_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int  m_upc, m_mode, m_held, m_fetch;
   bit  m_ill, m_to, m_valid;
   int  halt_age;

   micro_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .seq_ctl    (seq_ctl),
      .disp1_addr (disp1_addr),
      .disp2_addr (disp2_addr),
      .mem_ready  (mem_ready),
      .mc_done    (mc_done),
      .upc        (upc),
      .stall      (stall),
      .illegal_op (illegal_op),
      .timeout    (timeout),
      .halted     (halted),
      .fetch_cnt  (fetch_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_stall(input int c, input bit mr, input bit md);
      if (m_mode == M_HOLD) return 1'b1;
      if (m_mode == M_RUN && c == 4 && !mr) return 1'b1;
      if (m_mode == M_RUN && c == 5 && !md) return 1'b1;
      return 1'b0;
   endfunction

   // one clock of architectural behaviour; m_held counts stall cycles spent on the op so far
   task automatic model_step(input bit r, input int c, input int a1, input int a2,
                             input bit mr, input bit md);
      int d;
      if (!r) begin
         m_upc = 0; m_mode = M_RUN; m_held = 0; m_fetch = 0;
         m_ill = 0; m_to = 0; m_valid = 1;
         return;
      end
      if (m_mode == M_RUN) begin
         case (c)
            0: m_upc = (m_upc + 1) % 32;
            1, 7: begin m_upc = 0; m_fetch = (m_fetch + 1) % 65536; m_ill = 0; m_to = 0; end
            2, 3: begin
               d = (c == 2) ? a1 : a2;
               if (d == 31) begin m_upc = 30; m_ill = 1; end
               else m_upc = d;
            end
            4: if (mr) m_upc = (m_upc + 1) % 32;
            5: if (md) m_upc = (m_upc + 1) % 32;
               else begin m_mode = M_HOLD; m_held = 1; end
            6: m_mode = M_HALT;
            default: ;
         endcase
      end else if (m_mode == M_HOLD) begin
         if (md) begin
            m_upc = (m_upc + 1) % 32; m_mode = M_RUN;
         end else begin
            m_held++;
            if (m_held == MAX_WAIT) begin
               m_upc = 30; m_to = 1; m_mode = M_RUN;
            end
         end
      end
   endtask

   task automatic cyc(input bit r, input int c, input int a1, input int a2,
                      input bit mr, input bit md);
      rst_n      = r;
      seq_ctl    = 3'(c);
      disp1_addr = 5'(a1);
      disp2_addr = 5'(a2);
      mem_ready  = mr;
      mc_done    = md;
      #1;
      if (m_valid) chk("stall", 32'(stall), 32'(model_stall(c, mr, md)));
      @(posedge clk);
      model_step(r, c, a1, a2, mr, md);
      #1;
      chk("upc",        32'(upc),        32'(m_upc));
      chk("illegal_op", 32'(illegal_op), 32'(m_ill));
      chk("timeout",    32'(timeout),    32'(m_to));
      chk("halted",     32'(halted),     32'(m_mode == M_HALT));
      chk("fetch_cnt",  32'(fetch_cnt),  32'(m_fetch));
      halt_age = (m_mode == M_HALT) ? halt_age + 1 : 0;
   endtask

   initial begin
      m_valid = 0; halt_age = 0;
      m_upc = 0; m_mode = M_RUN; m_held = 0; m_fetch = 0; m_ill = 0; m_to = 0;
      rst_n = 1'b0; seq_ctl = 3'd0; disp1_addr = '0; disp2_addr = '0;
      mem_ready = 1'b0; mc_done = 1'b0;
      @(posedge clk); #1;

      // reset
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      #1 chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_upc", 32'(upc), 32'd0);

      // sequencing and dispatch
      repeat (3) cyc(1, 0, 0, 0, 0, 0);
      chk("next3_upc", 32'(upc), 32'd3);
      cyc(1, 2, 12, 0, 0, 0);
      chk("disp1_upc", 32'(upc), 32'd12);
      cyc(1, 3, 0, 19, 0, 0);
      chk("disp2_upc", 32'(upc), 32'd19);
      cyc(1, 2, 30, 0, 0, 0);                 // TRAP_ADDR loads unchanged, no flag
      chk("disp_trapaddr_ill", 32'(illegal_op), 32'd0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      chk("wrap_upc", 32'(upc), 32'd0);

      // illegal opcode
      cyc(1, 2, 31, 0, 0, 0);
      chk("illegal_upc", 32'(upc), 32'd30);
      chk("illegal_flag", 32'(illegal_op), 32'd1);
      cyc(1, 0, 0, 0, 0, 0);
      chk("illegal_sticky", 32'(illegal_op), 32'd1);
      cyc(1, 1, 0, 0, 0, 0);
      chk("fetch_clear", 32'(illegal_op), 32'd0);
      chk("fetch_cnt1", 32'(fetch_cnt), 32'd1);
      cyc(1, 3, 0, 31, 0, 0);                 // DISP2 illegal
      cyc(1, 7, 0, 0, 0, 0);                  // reserved acts as FETCH

      // multicycle stall, done after 5 stall cycles
      cyc(1, 2, 16, 0, 0, 0);
      repeat (5) cyc(1, 5, 0, 0, 0, 0);
      chk("mc_held", 32'(upc), 32'd16);
      cyc(1, 5, 0, 0, 0, 1);
      chk("mc_done_upc", 32'(upc), 32'd17);
      // done already present at entry
      cyc(1, 2, 16, 0, 0, 0);
      cyc(1, 5, 0, 0, 0, 1);
      chk("mc_fast_upc", 32'(upc), 32'd17);

      // timeout
      cyc(1, 2, 16, 0, 0, 0);
      repeat (MAX_WAIT) cyc(1, 5, 0, 0, 0, 0);
      chk("to_upc", 32'(upc), 32'd30);
      chk("to_flag", 32'(timeout), 32'd1);
      cyc(1, 1, 0, 0, 0, 0);
      // done arrives on the last hold cycle
      cyc(1, 2, 16, 0, 0, 0);
      repeat (MAX_WAIT - 1) cyc(1, 5, 0, 0, 0, 0);
      cyc(1, 5, 0, 0, 0, 1);
      chk("to_edge_upc", 32'(upc), 32'd17);
      chk("to_edge_flag", 32'(timeout), 32'd0);

      // memory wait
      repeat (3) cyc(1, 4, 0, 0, 0, 0);
      cyc(1, 4, 0, 0, 1, 0);
      chk("mem_upc", 32'(upc), 32'd18);

      // halt, then reset out of halt
      cyc(1, 6, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++)
         cyc(1, $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
             1'($urandom), 1'($urandom));
      chk("halt_upc", 32'(upc), 32'd18);
      cyc(0, 0, 0, 0, 0, 0);
      chk("halt_rst", 32'(halted), 32'd0);

      // reset during a multicycle hold
      cyc(1, 2, 9, 0, 0, 0);
      repeat (4) cyc(1, 5, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      #1 chk("hold_rst_stall", 32'(stall), 32'd0);
      cyc(1, 0, 0, 0, 0, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit r;
         int c;
         r = 1'b1;
         if (halt_age >= 4 || $urandom_range(0, 299) == 0) r = 1'b0;
         c = $urandom_range(0, 7);
         if (c == 6 && $urandom_range(0, 9) != 0) c = 0;
         cyc(r, c, $urandom_range(0, 31), $urandom_range(0, 31),
             1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
